ddr_frame_client: RTL and testbench
===================================

# ddr_frame_client

Initiator endpoint that talks to the DDR frame-buffer node across the NoC. It accepts Ethernet frames as a sop/eop beat stream, stamps each frame with a frame ID, and packs each beat into one NoC flit addressed to the DDR node. On the return path it unpacks flits from the DDR node into a beat stream, regenerates sop, and checks frame-ID sequence. It sits at any client router port; its NoC ports connect directly to the router.

## Interface
- DATA_WIDTH, 518: beat payload width.
- PORT_WIDTH, 600: NoC flit width.
- NUM_VC, 2: VCs; VC_ADDRESS_WIDTH = $clog2(NUM_VC).
- NOC_RADIX, 16: routers; ADDRESS_WIDTH = $clog2(NOC_RADIX).
- DDR_NODE, 0: destination router of the frame buffer.
- SRC_PORT, 0: 4-bit port tag, frame_id[31:28].
- ASSIGNED_VC, 0: VC field of every outgoing flit.
- MAX_BEATS, 32: maximum beats per frame.
- Derived: FRAME_ID_WIDTH = 32; WIDTH_PKT_IN = DATA_WIDTH+2+32; WIDTH_PKT_OUT = DATA_WIDTH+1+32.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- s_data  in  DATA_WIDTH  frame beat in.
- s_valid / s_sop / s_eop  in  1  beat qualifiers.
- s_ready  out  1  beat accepted when s_valid && s_ready.
- o_data_out  out  PORT_WIDTH  flit to NoC.
- o_valid_out  out  1; o_ready_in  in  1.
- i_data_in  in  PORT_WIDTH  flit from NoC.
- i_valid_in  in  1; i_ready_out  out  1.
- m_data  out  DATA_WIDTH; m_frame_id  out  32.
- m_valid / m_sop / m_eop  out  1; m_ready  in  1.
- tx_frame_count, rx_frame_count  out  16  wrapping frame counters.
- err_trunc, err_orphan, err_rx_seq  out  1  sticky error flags.

## Operation
- Outgoing flit: [DATA_WIDTH-1:0] data, then sop, eop, then 32-bit frame_id = {SRC_PORT, seq[27:0]}; bits [WIDTH_PKT_IN +: ADDRESS_WIDTH] = DDR_NODE; next VC_ADDRESS_WIDTH bits = ASSIGNED_VC; remaining bits 0.
- Incoming flit: [DATA_WIDTH-1:0] data, then eop, then 32-bit frame_id; remaining bits ignored.
- TX FSM states:
  - IDLE: a beat with sop sends a flit with sop=1 and the current seq. Goes to BODY, or stays in IDLE if eop is also set. A beat without sop is consumed and dropped, and err_orphan is set.
  - BODY: beats are sent with sop=0. An s_sop input here is ignored. The beat counter counts sent beats of the frame. On s_eop: flit eop=1, seq++, return to IDLE.
  - If the MAX_BEATS-th beat lacks eop, force eop=1, seq++, set err_trunc, and go to DROP.
  - DROP: s_ready=1, beats are discarded, no flits are sent. The beat with s_eop returns the FSM to IDLE.
- seq is 28 bits, starts at 0, and wraps at 2^28.
- TX output is a one-flit register: s_ready = !o_valid_out || o_ready_in (forced 1 in DROP). o_data_out and o_valid_out are held stable while o_valid_out && !o_ready_in.
- tx_frame_count increments on o_valid_out && o_ready_in with flit eop=1.
- RX output is a one-beat register: i_ready_out = !m_valid || m_ready.
- rx_first resets to 1. Each accepted flit takes m_sop = rx_first; rx_first becomes that flit's eop.
- On an accepted flit with m_sop: compare frame_id[27:0] to exp_seq (reset 0). On mismatch, set err_rx_seq. In both cases, exp_seq = received + 1.
- rx_frame_count increments on m_valid && m_ready && m_eop.
- TX and RX are independent, and both may transfer in the same cycle.

## Timing
- Reset (async assert): o_valid_out=0, o_data_out=0, m_valid=0, m_sop/m_eop=0, m_data/m_frame_id=0, counters=0, error flags=0, FSM=IDLE, seq=0, exp_seq=0, rx_first=1.
- s_ready and i_ready_out are combinational from registered state and the downstream ready. Both are 1 out of reset, except i_ready_out also depends on m_ready.
- Latency: accepted beat → o_valid_out next cycle. Accepted flit → m_valid next cycle.
- Full throughput, one beat per cycle each direction while the downstream ready stays high. Fill and drain are simultaneous when the register is full and ready is high.
- Reset mid-frame abandons the frame: no eop is emitted, and the next frame begins at seq 0.

## Test plan
- Frame of 4 beats (sop on beat 0, eop on beat 3), o_ready_in=1 → 4 flits on consecutive cycles. Dest field = DDR_NODE, frame_id = {SRC_PORT, 0}, only flit 3 eop. tx_frame_count=1.
- Backpressure: o_ready_in low 3 cycles mid-frame → o_data_out is held unchanged, s_ready=0, no beat is lost or duplicated.
- 40-beat frame, MAX_BEATS=32 → flit 32 carries eop, beats 33–40 are dropped, err_trunc=1. The next frame uses seq 1.
- Return flits with eop pattern 0,0,1,1 and frame_ids 0,0,0,1 → m_sop = 1,0,0,1, err_rx_seq=0, rx_frame_count=2.
- Return frame with seq 5 when 2 is expected → err_rx_seq=1. A following frame with seq 6 raises no new error.
- Beat without sop in IDLE → err_orphan=1, no flit sent. Reset asserted mid-frame → all outputs take their reset values immediately.

Source files
------------

// File: rtl/ddr_frame_client.sv
// ddr_frame_client: NoC initiator endpoint for the DDR frame buffer.
// TX path: sop/eop beat stream -> one flit per beat, stamped with a frame ID
// and addressed to the DDR node. RX path: flits from the DDR node -> beat
// stream with regenerated sop and frame-ID sequence checking.
module ddr_frame_client #(
   parameter int DATA_WIDTH  = 518,
   parameter int PORT_WIDTH  = 600,
   parameter int NUM_VC      = 2,
   parameter int NOC_RADIX   = 16,
   parameter int DDR_NODE    = 0,
   parameter int SRC_PORT    = 0,
   parameter int ASSIGNED_VC = 0,
   parameter int MAX_BEATS   = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   // frame beat input
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   input  logic                  s_sop,
   input  logic                  s_eop,
   output logic                  s_ready,
   // NoC flit output
   output logic [PORT_WIDTH-1:0] o_data_out,
   output logic                  o_valid_out,
   input  logic                  o_ready_in,
   // NoC flit input
   input  logic [PORT_WIDTH-1:0] i_data_in,
   input  logic                  i_valid_in,
   output logic                  i_ready_out,
   // frame beat output
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [31:0]           m_frame_id,
   output logic                  m_valid,
   output logic                  m_sop,
   output logic                  m_eop,
   input  logic                  m_ready,
   // status
   output logic [15:0]           tx_frame_count,
   output logic [15:0]           rx_frame_count,
   output logic                  err_trunc,
   output logic                  err_orphan,
   output logic                  err_rx_seq
);

   localparam int VC_ADDRESS_WIDTH = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
   localparam int ADDRESS_WIDTH    = (NOC_RADIX > 1) ? $clog2(NOC_RADIX) : 1;
   localparam int FRAME_ID_WIDTH   = 32;
   localparam int WIDTH_PKT_IN     = DATA_WIDTH + 2 + FRAME_ID_WIDTH;
   localparam int WIDTH_PKT_OUT    = DATA_WIDTH + 1 + FRAME_ID_WIDTH;
   localparam int BEAT_CNT_W       = $clog2(MAX_BEATS + 1);

   localparam logic [3:0]                  SRC_TAG   = 4'(SRC_PORT);
   localparam logic [ADDRESS_WIDTH-1:0]    DEST_ADDR = ADDRESS_WIDTH'(DDR_NODE);
   localparam logic [VC_ADDRESS_WIDTH-1:0] VC_ID     = VC_ADDRESS_WIDTH'(ASSIGNED_VC);
   localparam logic [BEAT_CNT_W-1:0]       LAST_BEAT = BEAT_CNT_W'(MAX_BEATS - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_BODY, ST_DROP} tx_state_t;

   // ------------------------------------------------------------------ TX
   tx_state_t               state_reg, state_next;
   logic [BEAT_CNT_W-1:0]   beat_cnt_reg;
   logic [27:0]             seq_reg;
   logic [PORT_WIDTH-1:0]   o_data_reg;
   logic                    o_valid_reg;
   logic [15:0]             tx_cnt_reg;
   logic                    err_trunc_reg, err_orphan_reg;

   logic                    s_ready_int, s_fire;
   logic [BEAT_CNT_W-1:0]   beats_before;
   logic                    at_limit;
   logic                    send, flit_sop, flit_eop, trunc, orphan;
   logic [PORT_WIDTH-1:0]   flit_next;

   // TX state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= ST_IDLE;
      else       state_reg <= state_next;
   end

   // TX per-beat decisions: accept, send or drop, sop/eop of the flit, errors
   always_comb begin
      s_ready_int  = (state_reg == ST_DROP) || !o_valid_reg || o_ready_in;
      s_fire       = s_valid && s_ready_int;
      beats_before = (state_reg == ST_BODY) ? beat_cnt_reg : '0;
      at_limit     = (beats_before == LAST_BEAT);
      send         = 1'b0;
      flit_sop     = 1'b0;
      flit_eop     = 1'b0;
      trunc        = 1'b0;
      orphan       = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (s_fire) begin
               if (s_sop) begin
                  send     = 1'b1;
                  flit_sop = 1'b1;
                  flit_eop = s_eop || at_limit;
                  trunc    = at_limit && !s_eop;
               end else begin
                  orphan = 1'b1;
               end
            end
         end
         ST_BODY: begin
            if (s_fire) begin
               send     = 1'b1;
               flit_eop = s_eop || at_limit;
               trunc    = at_limit && !s_eop;
            end
         end
         default: ;
      endcase
   end

   // TX next-state selection
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (s_fire && s_sop) begin
               if (trunc)       state_next = ST_DROP;
               else if (!s_eop) state_next = ST_BODY;
            end
         end
         ST_BODY: begin
            if (s_fire) begin
               if (trunc)      state_next = ST_DROP;
               else if (s_eop) state_next = ST_IDLE;
            end
         end
         ST_DROP: begin
            if (s_fire && s_eop) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Flit assembly: payload, sop/eop, frame ID, routing header, zero padding
   always_comb begin
      flit_next                                                  = '0;
      flit_next[DATA_WIDTH-1:0]                                  = s_data;
      flit_next[DATA_WIDTH]                                      = flit_sop;
      flit_next[DATA_WIDTH+1]                                    = flit_eop;
      flit_next[DATA_WIDTH+2 +: FRAME_ID_WIDTH]                  = {SRC_TAG, seq_reg};
      flit_next[WIDTH_PKT_IN +: ADDRESS_WIDTH]                   = DEST_ADDR;
      flit_next[WIDTH_PKT_IN+ADDRESS_WIDTH +: VC_ADDRESS_WIDTH]  = VC_ID;
   end

   // TX datapath: output flit register, beat counter, sequence, counters, flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_data_reg     <= '0;
         o_valid_reg    <= 1'b0;
         beat_cnt_reg   <= '0;
         seq_reg        <= '0;
         tx_cnt_reg     <= '0;
         err_trunc_reg  <= 1'b0;
         err_orphan_reg <= 1'b0;
      end else begin
         if (o_valid_reg && o_ready_in && o_data_reg[DATA_WIDTH+1])
            tx_cnt_reg <= tx_cnt_reg + 16'd1;
         if (send) begin
            o_data_reg  <= flit_next;
            o_valid_reg <= 1'b1;
            if (flit_eop) begin
               beat_cnt_reg <= '0;
               seq_reg      <= seq_reg + 28'd1;
            end else begin
               beat_cnt_reg <= beats_before + 1'b1;
            end
         end else if (o_ready_in) begin
            o_valid_reg <= 1'b0;
         end
         if (trunc)  err_trunc_reg  <= 1'b1;
         if (orphan) err_orphan_reg <= 1'b1;
      end
   end

   assign s_ready        = s_ready_int;
   assign o_data_out     = o_data_reg;
   assign o_valid_out    = o_valid_reg;
   assign tx_frame_count = tx_cnt_reg;
   assign err_trunc      = err_trunc_reg;
   assign err_orphan     = err_orphan_reg;

   // ------------------------------------------------------------------ RX
   logic [DATA_WIDTH-1:0] m_data_reg;
   logic [31:0]           m_fid_reg;
   logic                  m_valid_reg, m_sop_reg, m_eop_reg;
   logic                  rx_first_reg;
   logic [27:0]           exp_seq_reg;
   logic [15:0]           rx_cnt_reg;
   logic                  err_rx_seq_reg;

   logic                  i_fire;
   logic                  rx_eop;
   logic [31:0]           rx_fid;
   logic                  unused_rx_bits;

   assign i_ready_out    = !m_valid_reg || m_ready;
   assign i_fire         = i_valid_in && i_ready_out;
   assign rx_eop         = i_data_in[DATA_WIDTH];
   assign rx_fid         = i_data_in[DATA_WIDTH+1 +: FRAME_ID_WIDTH];
   assign unused_rx_bits = ^i_data_in[PORT_WIDTH-1:WIDTH_PKT_OUT];

   // RX datapath: output beat register, sop regeneration, sequence check
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_data_reg     <= '0;
         m_fid_reg      <= '0;
         m_valid_reg    <= 1'b0;
         m_sop_reg      <= 1'b0;
         m_eop_reg      <= 1'b0;
         rx_first_reg   <= 1'b1;
         exp_seq_reg    <= '0;
         rx_cnt_reg     <= '0;
         err_rx_seq_reg <= 1'b0;
      end else begin
         if (m_valid_reg && m_ready && m_eop_reg)
            rx_cnt_reg <= rx_cnt_reg + 16'd1;
         if (i_fire) begin
            m_data_reg   <= i_data_in[DATA_WIDTH-1:0];
            m_fid_reg    <= rx_fid;
            m_eop_reg    <= rx_eop;
            m_sop_reg    <= rx_first_reg;
            m_valid_reg  <= 1'b1;
            rx_first_reg <= rx_eop;
            if (rx_first_reg) begin
               if (rx_fid[27:0] != exp_seq_reg) err_rx_seq_reg <= 1'b1;
               exp_seq_reg <= rx_fid[27:0] + 28'd1;
            end
         end else if (m_ready) begin
            m_valid_reg <= 1'b0;
         end
      end
   end

   assign m_data         = m_data_reg;
   assign m_frame_id     = m_fid_reg;
   assign m_valid        = m_valid_reg;
   assign m_sop          = m_sop_reg;
   assign m_eop          = m_eop_reg;
   assign rx_frame_count = rx_cnt_reg;
   assign err_rx_seq     = err_rx_seq_reg;

endmodule

// File: tb/tb_ddr_frame_client.sv
// Directed bench for ddr_frame_client: table-driven TX and RX vectors plus
// hand sequences for backpressure, truncation, orphan beats and reset.
module tb_ddr_frame_client;

   localparam int DW = 518;
   localparam int PW = 600;
   localparam int PKT_IN = DW + 2 + 32;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] s_data;
   logic          s_valid, s_sop, s_eop, s_ready;
   logic [PW-1:0] o_data_out;
   logic          o_valid_out, o_ready_in;
   logic [PW-1:0] i_data_in;
   logic          i_valid_in, i_ready_out;
   logic [DW-1:0] m_data;
   logic [31:0]   m_frame_id;
   logic          m_valid, m_sop, m_eop, m_ready;
   logic [15:0]   tx_frame_count, rx_frame_count;
   logic          err_trunc, err_orphan, err_rx_seq;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ddr_frame_client dut (
      .clk(clk), .reset(reset),
      .s_data(s_data), .s_valid(s_valid), .s_sop(s_sop), .s_eop(s_eop), .s_ready(s_ready),
      .o_data_out(o_data_out), .o_valid_out(o_valid_out), .o_ready_in(o_ready_in),
      .i_data_in(i_data_in), .i_valid_in(i_valid_in), .i_ready_out(i_ready_out),
      .m_data(m_data), .m_frame_id(m_frame_id), .m_valid(m_valid), .m_sop(m_sop),
      .m_eop(m_eop), .m_ready(m_ready),
      .tx_frame_count(tx_frame_count), .rx_frame_count(rx_frame_count),
      .err_trunc(err_trunc), .err_orphan(err_orphan), .err_rx_seq(err_rx_seq)
   );

   typedef struct {
      logic          sop;
      logic          eop;
      logic [DW-1:0] data;
      logic          exp_sop;
      logic          exp_eop;
      logic [27:0]   exp_seq;
   } tx_vec_t;

   typedef struct {
      logic          eop;
      logic [31:0]   fid;
      logic [DW-1:0] data;
      logic          exp_sop;
      logic          exp_err;
      logic [15:0]   exp_cnt;
   } rx_vec_t;

   tx_vec_t tx_tab[7];
   rx_vec_t rx_tab[6];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk_data(input int k);
      logic [DW-1:0] d;
      d = '0;
      d[DW-1] = 1'b1;
      d[31:0] = 32'(k) ^ 32'hA5A5_0000;
      return d;
   endfunction

   // expected outgoing flit, built independently from the field layout
   function automatic logic [PW-1:0] mk_flit(input logic [DW-1:0] d, input logic sop,
                                              input logic eop, input logic [27:0] seq);
      logic [PW-1:0] f;
      f = '0;
      f[DW-1:0]       = d;
      f[DW]           = sop;
      f[DW+1]         = eop;
      f[DW+2 +: 32]   = {4'd0, seq};
      f[PKT_IN +: 4]  = 4'd0;
      f[PKT_IN + 4]   = 1'b0;
      return f;
   endfunction

   // incoming flit with junk in the ignored upper bits
   function automatic logic [PW-1:0] mk_rx(input logic [DW-1:0] d, input logic eop,
                                            input logic [31:0] fid);
      logic [PW-1:0] f;
      f = '0;
      f[DW-1:0]     = d;
      f[DW]         = eop;
      f[DW+1 +: 32] = fid;
      f[PW-1]       = 1'b1;
      f[560]        = 1'b1;
      return f;
   endfunction

   task automatic send_beat(input logic sop, input logic eop, input logic [DW-1:0] d);
      s_valid = 1'b1;
      s_sop   = sop;
      s_eop   = eop;
      s_data  = d;
   endtask

   initial begin
      // frame A: 4 beats seq 0; frame B: single beat seq 1;
      // frame C: 2 beats seq 2, second beat carries a stray sop
      tx_tab[0] = '{1'b1, 1'b0, mk_data(0),  1'b1, 1'b0, 28'd0};
      tx_tab[1] = '{1'b0, 1'b0, mk_data(1),  1'b0, 1'b0, 28'd0};
      tx_tab[2] = '{1'b0, 1'b0, mk_data(2),  1'b0, 1'b0, 28'd0};
      tx_tab[3] = '{1'b0, 1'b1, mk_data(3),  1'b0, 1'b1, 28'd0};
      tx_tab[4] = '{1'b1, 1'b1, mk_data(10), 1'b1, 1'b1, 28'd1};
      tx_tab[5] = '{1'b1, 1'b0, mk_data(20), 1'b1, 1'b0, 28'd2};
      tx_tab[6] = '{1'b1, 1'b1, mk_data(21), 1'b0, 1'b1, 28'd2};

      // eop 0,0,1,1 with ids 0,0,0,1; then id 5 (2 expected) and id 6
      rx_tab[0] = '{1'b0, 32'd0, mk_data(50), 1'b1, 1'b0, 16'd0};
      rx_tab[1] = '{1'b0, 32'd0, mk_data(51), 1'b0, 1'b0, 16'd0};
      rx_tab[2] = '{1'b1, 32'd0, mk_data(52), 1'b0, 1'b0, 16'd0};
      rx_tab[3] = '{1'b1, 32'd1, mk_data(53), 1'b1, 1'b0, 16'd1};
      rx_tab[4] = '{1'b1, 32'd5, mk_data(54), 1'b1, 1'b1, 16'd2};
      rx_tab[5] = '{1'b1, 32'd6, mk_data(55), 1'b1, 1'b1, 16'd3};

      reset = 1'b1; s_valid = 0; s_sop = 0; s_eop = 0; s_data = '0;
      o_ready_in = 1'b1; i_valid_in = 0; i_data_in = '0; m_ready = 1'b1;
      #12;
      chk("rst_o_valid", o_valid_out, 0);
      chk("rst_o_data", o_data_out, 0);
      chk("rst_s_ready", s_ready, 1);
      chk("rst_i_ready", i_ready_out, 1);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_counts", {tx_frame_count, rx_frame_count}, 0);
      chk("rst_errs", {err_trunc, err_orphan, err_rx_seq}, 0);
      @(negedge clk);
      reset = 1'b0;
      tick;

      // ---------------- TX table
      for (int i = 0; i < 7; i++) begin
         send_beat(tx_tab[i].sop, tx_tab[i].eop, tx_tab[i].data);
         #1;
         chk("tx_s_ready", s_ready, 1);
         tick;
         chk("tx_o_valid", o_valid_out, 1);
         chk("tx_flit", o_data_out,
             mk_flit(tx_tab[i].data, tx_tab[i].exp_sop, tx_tab[i].exp_eop, tx_tab[i].exp_seq));
         $display("tx vec %0d: sop=%0b eop=%0b seq=%0d flit_sop=%0b flit_eop=%0b", i,
                  tx_tab[i].sop, tx_tab[i].eop, tx_tab[i].exp_seq,
                  o_data_out[DW], o_data_out[DW+1]);
      end
      s_valid = 1'b0;
      tick;
      chk("tx_drained", o_valid_out, 0);
      chk("tx_count3", tx_frame_count, 3);

      // ---------------- backpressure: frame seq 3, 5 beats
      send_beat(1'b1, 1'b0, mk_data(100));
      tick;
      chk("bp_flit0", o_data_out, mk_flit(mk_data(100), 1, 0, 28'd3));
      o_ready_in = 1'b0;
      send_beat(1'b0, 1'b0, mk_data(101));
      #1;
      chk("bp_s_ready_low", s_ready, 0);
      for (int c = 0; c < 3; c++) begin
         tick;
         chk("bp_hold_data", o_data_out, mk_flit(mk_data(100), 1, 0, 28'd3));
         chk("bp_hold_valid", o_valid_out, 1);
         chk("bp_s_ready", s_ready, 0);
         $display("bp stall cycle %0d: o_valid=%0b s_ready=%0b", c, o_valid_out, s_ready);
      end
      o_ready_in = 1'b1;
      #1;
      chk("bp_s_ready_high", s_ready, 1);
      for (int k = 1; k < 5; k++) begin
         send_beat(1'b0, (k == 4), mk_data(100 + k));
         tick;
         chk("bp_flit", o_data_out, mk_flit(mk_data(100 + k), 0, (k == 4), 28'd3));
         $display("bp beat %0d: flit_eop=%0b", k, o_data_out[DW+1]);
      end
      s_valid = 1'b0;
      tick;
      chk("bp_count4", tx_frame_count, 4);

      // ---------------- truncation: 40-beat frame, seq 4
      for (int k = 0; k < 40; k++) begin
         send_beat((k == 0), (k == 39), mk_data(1000 + k));
         #1;
         chk("tr_s_ready", s_ready, 1);
         tick;
         if (k < 32) begin
            chk("tr_valid", o_valid_out, 1);
            chk("tr_flit", o_data_out, mk_flit(mk_data(1000 + k), (k == 0), (k == 31), 28'd4));
         end else begin
            chk("tr_dropped", o_valid_out, 0);
         end
         $display("trunc beat %0d: o_valid=%0b", k, o_valid_out);
      end
      s_valid = 1'b0;
      tick;
      chk("tr_err", err_trunc, 1);
      chk("tr_count5", tx_frame_count, 5);
      send_beat(1'b1, 1'b1, mk_data(200));
      tick;
      chk("tr_next_seq", o_data_out, mk_flit(mk_data(200), 1, 1, 28'd5));
      s_valid = 1'b0;
      tick;

      // ---------------- orphan beat in IDLE
      chk("orph_before", err_orphan, 0);
      send_beat(1'b0, 1'b0, mk_data(300));
      #1;
      chk("orph_s_ready", s_ready, 1);
      tick;
      chk("orph_no_flit", o_valid_out, 0);
      chk("orph_err", err_orphan, 1);
      send_beat(1'b1, 1'b1, mk_data(301));
      tick;
      chk("orph_next", o_data_out, mk_flit(mk_data(301), 1, 1, 28'd6));
      $display("orphan: err_orphan=%0b next seq flit sent", err_orphan);
      s_valid = 1'b0;
      tick;

      // ---------------- RX table
      for (int i = 0; i < 6; i++) begin
         i_valid_in = 1'b1;
         i_data_in  = mk_rx(rx_tab[i].data, rx_tab[i].eop, rx_tab[i].fid);
         #1;
         chk("rx_i_ready", i_ready_out, 1);
         tick;
         chk("rx_m_valid", m_valid, 1);
         chk("rx_m_sop", m_sop, rx_tab[i].exp_sop);
         chk("rx_m_eop", m_eop, rx_tab[i].eop);
         chk("rx_m_fid", m_frame_id, rx_tab[i].fid);
         chk("rx_m_data", m_data, rx_tab[i].data);
         chk("rx_err_seq", err_rx_seq, rx_tab[i].exp_err);
         chk("rx_count", rx_frame_count, rx_tab[i].exp_cnt);
         $display("rx vec %0d: fid=%0d eop=%0b m_sop=%0b err_rx_seq=%0b rx_count=%0d", i,
                  rx_tab[i].fid, rx_tab[i].eop, m_sop, err_rx_seq, rx_frame_count);
      end
      i_valid_in = 1'b0;
      tick;
      chk("rx_drained", m_valid, 0);
      chk("rx_count4", rx_frame_count, 4);

      // ---------------- RX backpressure
      m_ready    = 1'b0;
      i_valid_in = 1'b1;
      i_data_in  = mk_rx(mk_data(60), 1'b1, 32'd7);
      tick;
      i_data_in  = mk_rx(mk_data(61), 1'b1, 32'd8);
      #1;
      chk("rxbp_i_ready_low", i_ready_out, 0);
      tick;
      tick;
      chk("rxbp_hold_fid", m_frame_id, 32'd7);
      m_ready = 1'b1;
      #1;
      chk("rxbp_i_ready_high", i_ready_out, 1);
      tick;
      chk("rxbp_next_fid", m_frame_id, 32'd8);
      chk("rxbp_next_sop", m_sop, 1);
      $display("rx backpressure: held fid 7 then fid 8 delivered");
      i_valid_in = 1'b0;
      m_ready    = 1'b0;
      tick;

      // ---------------- reset mid-frame
      send_beat(1'b1, 1'b0, mk_data(400));
      tick;
      chk("mid_o_valid", o_valid_out, 1);
      s_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("arst_o_valid", o_valid_out, 0);
      chk("arst_o_data", o_data_out, 0);
      chk("arst_m_out", {m_valid, m_sop, m_eop}, 0);
      chk("arst_m_data", m_data, 0);
      chk("arst_m_fid", m_frame_id, 0);
      chk("arst_counts", {tx_frame_count, rx_frame_count}, 0);
      chk("arst_errs", {err_trunc, err_orphan, err_rx_seq}, 0);
      chk("arst_readies", {s_ready, i_ready_out}, 2'b11);
      $display("async reset mid-frame applied");
      @(negedge clk);
      reset   = 1'b0;
      m_ready = 1'b1;
      send_beat(1'b1, 1'b1, mk_data(500));
      i_valid_in = 1'b1;
      i_data_in  = mk_rx(mk_data(70), 1'b1, 32'd0);
      tick;
      chk("post_rst_seq0", o_data_out, mk_flit(mk_data(500), 1, 1, 28'd0));
      chk("post_rst_rx_sop", m_sop, 1);
      chk("post_rst_rx_err", err_rx_seq, 0);
      $display("post reset: tx seq 0 flit and rx frame 0 accepted");
      s_valid    = 1'b0;
      i_valid_in = 1'b0;
      tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
